// File: rtl/diff_ctrl_pkg.sv
// Shared types and defaults for the frame-differencing sequencer.
package diff_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    WAIT    = 3'd2,
    STORE   = 3'd3,
    COMPARE = 3'd4
  } state_t;

  // {x[0], y[0]} of the pixel kept by the 2x2 subsampler
  localparam logic [1:0] SUB_PHASE_DEF = 2'b10;

endpackage

// File: rtl/frame_edge_det.sv
// Frame-boundary detector: one-cycle pulse whenever the capture frame counter changes.
module frame_edge_det #(
  parameter int W = 32
) (
  input  logic         iCLK,
  input  logic [W-1:0] iFrame_Cont,
  output logic         oFb
);

  logic [W-1:0] frame_q;

  // Tracks the counter in every cycle, reset included, so no spurious pulse follows reset.
  always_ff @(posedge iCLK) begin
    frame_q <= iFrame_Cont;
  end

  assign oFb = (iFrame_Cont != frame_q);

endmodule

// File: rtl/diff_frame_ctrl.sv
// Reference-frame FIFO sequencer: stores one subsampled frame, compares the next against it,
// and publishes a frame-qualified detection flag with integrity checking.
module diff_frame_ctrl
  import diff_ctrl_pkg::*;
#(
  parameter int         X_W       = 10,
  parameter int         Y_W       = 9,
  parameter logic [1:0] SUB_PHASE = SUB_PHASE_DEF,
  parameter int         MIN_HITS  = 30,
  parameter int         CNT_W     = 16
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iEnable,
  input  logic             iDVAL,
  input  logic [31:0]      iFrame_Cont,
  input  logic [X_W-1:0]   iX_Cont,
  input  logic [Y_W-1:0]   iY_Cont,
  input  logic             iFifoEmpty,
  input  logic             iHit,
  output logic             oWrReq,
  output logic             oRdReq,
  output logic             oFifoClr,
  output logic             oObjectDetected,
  output logic [CNT_W-1:0] oHitCount,
  output logic             oSyncErr,
  output logic [2:0]       oState
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HIT_THR = CNT_W'(MIN_HITS);

  state_t           state_q, state_d, eff_state;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, hit_out_q, hit_out_d, hit_final;
  logic             sync_err_q, sync_err_d, obj_q, obj_d, clr_q, clr_d, rd_req_q;
  logic             fb, samp, mismatch, wr_req, rd_req;
  logic             unused_xy;

  frame_edge_det #(.W(32)) u_edge (
    .iCLK        (iCLK),
    .iFrame_Cont (iFrame_Cont),
    .oFb         (fb)
  );

  assign samp      = iDVAL && ({iX_Cont[0], iY_Cont[0]} == SUB_PHASE);
  assign unused_xy = ^{iX_Cont[X_W-1:1], iY_Cont[Y_W-1:1]};

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      hit_cnt_q  <= '0;
      hit_out_q  <= '0;
      sync_err_q <= 1'b0;
      obj_q      <= 1'b0;
      clr_q      <= 1'b0;
      rd_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      hit_out_q  <= hit_out_d;
      sync_err_q <= sync_err_d;
      obj_q      <= obj_d;
      clr_q      <= clr_d;
      rd_req_q   <= rd_req;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    hit_out_d  = hit_out_q;
    sync_err_d = sync_err_q;
    obj_d      = obj_q;
    clr_d      = 1'b0;
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    eff_state  = state_q;
    // A hit landing in the boundary cycle still belongs to the frame that just ended.
    hit_final  = hit_cnt_q;
    if (rd_req_q && iHit && (hit_cnt_q != CNT_MAX)) hit_final = hit_cnt_q + 1'b1;
    mismatch   = (rd_cnt_q != wr_cnt_q) || !iFifoEmpty || sync_err_q;

    case (state_q)
      IDLE:    if (fb && iEnable) state_d = FLUSH;
      FLUSH:   state_d = WAIT;
      WAIT:    if (fb) state_d = iEnable ? STORE : IDLE;
      STORE:   if (fb) state_d = iEnable ? COMPARE : IDLE;
      COMPARE: begin
        hit_cnt_d = hit_final;
        if (fb) begin
          if (!iEnable) begin
            state_d = IDLE;
          end else if (mismatch) begin
            state_d    = FLUSH;
            sync_err_d = 1'b1;
          end else begin
            state_d   = STORE;
            obj_d     = (hit_final >= HIT_THR);
            hit_out_d = hit_final;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      clr_d = (state_d == FLUSH) || (state_d == IDLE);
      if (state_d == IDLE) obj_d = 1'b0;
      if (state_d == STORE) begin
        wr_cnt_d   = '0;
        sync_err_d = 1'b0;
      end
      if (state_d == COMPARE) begin
        rd_cnt_d  = '0;
        hit_cnt_d = '0;
      end
    end

    // A sample coinciding with a boundary is handled by the phase being entered.
    if (fb) eff_state = state_d;
    if (samp && (eff_state == STORE)) begin
      wr_req = 1'b1;
      if (wr_cnt_d == CNT_MAX) sync_err_d = 1'b1;
      else                     wr_cnt_d   = wr_cnt_d + 1'b1;
    end
    if (samp && (eff_state == COMPARE)) begin
      if (iFifoEmpty) begin
        sync_err_d = 1'b1;
      end else begin
        rd_req = 1'b1;
        if (rd_cnt_d != CNT_MAX) rd_cnt_d = rd_cnt_d + 1'b1;
      end
    end
  end

  assign oWrReq          = wr_req;
  assign oRdReq          = rd_req;
  assign oFifoClr        = clr_q;
  assign oObjectDetected = obj_q;
  assign oHitCount       = hit_out_q;
  assign oSyncErr        = sync_err_q;
  assign oState          = state_q;

endmodule

// File: tb/tb_diff_frame_ctrl.sv
// Directed bench for diff_frame_ctrl: per-pixel strobe scoreboard plus per-frame decision checks.
module tb_diff_frame_ctrl;
  import diff_ctrl_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST, iEnable, iDVAL, iFifoEmpty, iHit;
  logic [31:0] iFrame_Cont;
  logic [9:0]  iX_Cont;
  logic [8:0]  iY_Cont;
  logic        oWrReq, oRdReq, oFifoClr, oObjectDetected, oSyncErr;
  logic [15:0] oHitCount;
  logic [2:0]  oState;

  int          n_chk = 0, n_pass = 0, n_fail = 0, fifo_lvl = 0;
  logic        hit_pend = 1'b0;
  logic [1:0]  sb_q[$];
  logic [16:0] dec_q[$];

  diff_frame_ctrl dut (
    .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iDVAL(iDVAL),
    .iFrame_Cont(iFrame_Cont), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iFifoEmpty(iFifoEmpty), .iHit(iHit),
    .oWrReq(oWrReq), .oRdReq(oRdReq), .oFifoClr(oFifoClr),
    .oObjectDetected(oObjectDetected), .oHitCount(oHitCount),
    .oSyncErr(oSyncErr), .oState(oState)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, leave the caller 2ns before the rising edge.
  task automatic cyc(input logic dval, input int x, input int y, input logic empty, input logic bump);
    @(negedge iCLK);
    if (bump) iFrame_Cont = iFrame_Cont + 1;
    iDVAL = dval; iX_Cont = 10'(x); iY_Cont = 9'(y);
    iFifoEmpty = empty; iHit = hit_pend; hit_pend = 1'b0;
    #3;
  endtask

  task automatic blank();
    cyc(1'b0, 0, 0, fifo_lvl == 0, 1'b0);
  endtask

  // Frame boundary, then the following cycle where the new state is visible.
  task automatic adv(input state_t exp_st, input string tag);
    cyc(1'b0, 0, 0, fifo_lvl == 0, 1'b1);
    blank();
    chk(tag, 32'(oState), 32'(exp_st));
  endtask

  task automatic pop_dec(input string tag);
    logic [16:0] d;
    d = dec_q.pop_front();
    chk({tag, "_det"}, 32'(oObjectDetected), 32'(d[16]));
    chk({tag, "_hitcnt"}, 32'(oHitCount), 32'(d[15:0]));
  endtask

  // kind: 0 no strobes, 1 writes, 2 reads. Hits land on the last nhits reads.
  task automatic frame(input int nx, input int ny, input int kind, input int nhits,
                       input int empty_from, input int drop_at, input int rst_at);
    int nsamp, sidx, ridx;
    logic samp, empty, ewr, erd;
    logic [1:0] exp;
    nsamp = (nx / 2) * ((ny + 1) / 2);
    sidx = 0; ridx = 0;
    for (int yy = ny - 1; yy >= 0; yy--) begin
      for (int x = 0; x < nx; x++) begin
        samp  = (x % 2 == 1) && (yy % 2 == 0);
        empty = (fifo_lvl == 0) || (empty_from >= 0 && sidx >= empty_from);
        ewr   = (kind == 1) && samp;
        erd   = (kind == 2) && samp && !empty;
        cyc(1'b1, x, yy, empty, 1'b0);
        sb_q.push_back({ewr, erd});
        exp = sb_q.pop_front();
        chk("strobe", 32'({oWrReq, oRdReq}), 32'(exp));
        if (ewr) fifo_lvl++;
        if (erd) begin
          hit_pend = (ridx >= nsamp - nhits);
          ridx++;
          fifo_lvl--;
        end
        if (samp) begin
          if (sidx == drop_at) iEnable = 1'b0;
          if (sidx == rst_at) begin
            iRST = 1'b0;
            blank();
            iRST = 1'b1;
            kind = 0;
            fifo_lvl = 0;
            chk("midrst_state", 32'(oState), 32'(IDLE));
            chk("midrst_flags", 32'({oWrReq, oRdReq, oFifoClr, oObjectDetected, oSyncErr}), 32'd0);
            chk("midrst_hitcnt", 32'(oHitCount), 32'd0);
          end
          sidx++;
        end
      end
    end
  endtask

  initial begin
    iRST = 1'b0; iEnable = 1'b1; iDVAL = 1'b0; iFrame_Cont = 32'd0;
    iX_Cont = '0; iY_Cont = '0; iFifoEmpty = 1'b1; iHit = 1'b0;
    blank(); blank();
    chk("rst_state", 32'(oState), 32'(IDLE));
    chk("rst_flags", 32'({oWrReq, oRdReq, oFifoClr, oObjectDetected, oSyncErr}), 32'd0);
    chk("rst_hitcnt", 32'(oHitCount), 32'd0);
    iRST = 1'b1;
    blank();
    chk("idle_no_fb", 32'(oState), 32'(IDLE));

    // start-up: FLUSH, WAIT, then the 3-frame basic run with no hits
    adv(FLUSH, "st_flush0");
    chk("clr_pulse0", 32'(oFifoClr), 32'd1);
    blank();
    chk("st_wait0", 32'(oState), 32'(WAIT));
    chk("clr_end0", 32'(oFifoClr), 32'd0);
    frame(8, 4, 0, 0, -1, -1, -1);
    adv(STORE, "st_store1");
    frame(8, 4, 1, 0, -1, -1, -1);
    adv(COMPARE, "st_cmp1");
    frame(8, 4, 2, 0, -1, -1, -1);
    dec_q.push_back({1'b0, 16'd0});
    adv(STORE, "st_store2");
    pop_dec("nohit");
    chk("err_clean", 32'(oSyncErr), 32'd0);

    // 29 hits: just under threshold
    frame(16, 8, 1, 0, -1, -1, -1);
    adv(COMPARE, "st_cmp29");
    frame(16, 8, 2, 29, -1, -1, -1);
    dec_q.push_back({1'b0, 16'd29});
    adv(STORE, "st_store29");
    pop_dec("hit29");

    // 30 hits: last one arrives in the boundary cycle
    frame(16, 8, 1, 0, -1, -1, -1);
    adv(COMPARE, "st_cmp30");
    frame(16, 8, 2, 30, -1, -1, -1);
    dec_q.push_back({1'b1, 16'd30});
    cyc(1'b0, 0, 0, fifo_lvl == 0, 1'b1);
    chk("det_latency", 32'(oObjectDetected), 32'd0);
    blank();
    chk("st_store30", 32'(oState), 32'(STORE));
    pop_dec("hit30");

    // FIFO underflow mid-COMPARE
    frame(8, 4, 1, 0, -1, -1, -1);
    adv(COMPARE, "st_cmp_uf");
    frame(8, 4, 2, 0, 4, -1, -1);
    chk("uflow_err", 32'(oSyncErr), 32'd1);
    adv(FLUSH, "uflow_flush");
    fifo_lvl = 0;
    chk("uflow_clr", 32'(oFifoClr), 32'd1);
    chk("uflow_det_held", 32'(oObjectDetected), 32'd1);
    chk("uflow_cnt_held", 32'(oHitCount), 32'd30);
    blank();
    chk("uflow_wait", 32'(oState), 32'(WAIT));
    chk("uflow_clr_end", 32'(oFifoClr), 32'd0);
    chk("uflow_err_sticky", 32'(oSyncErr), 32'd1);
    frame(8, 4, 0, 0, -1, -1, -1);
    adv(STORE, "uflow_restore");
    chk("uflow_err_cleared", 32'(oSyncErr), 32'd0);

    // count mismatch: 8 written, 6 read
    frame(8, 4, 1, 0, -1, -1, -1);
    adv(COMPARE, "st_cmp_mm");
    frame(6, 4, 2, 0, -1, -1, -1);
    adv(FLUSH, "mm_flush");
    fifo_lvl = 0;
    chk("mm_err", 32'(oSyncErr), 32'd1);
    chk("mm_clr", 32'(oFifoClr), 32'd1);
    blank();
    chk("mm_wait", 32'(oState), 32'(WAIT));
    frame(8, 4, 0, 0, -1, -1, -1);
    adv(STORE, "mm_store");
    chk("mm_err_cleared", 32'(oSyncErr), 32'd0);

    // detection set, then iEnable dropped during COMPARE
    frame(16, 8, 1, 0, -1, -1, -1);
    adv(COMPARE, "st_cmp32");
    frame(16, 8, 2, 32, -1, -1, -1);
    dec_q.push_back({1'b1, 16'd32});
    adv(STORE, "st_store32");
    pop_dec("hit32");
    frame(8, 4, 1, 0, -1, -1, -1);
    adv(COMPARE, "st_cmp_dis");
    frame(8, 4, 2, 0, -1, 3, -1);
    adv(IDLE, "dis_idle");
    fifo_lvl = 0;
    chk("dis_clr", 32'(oFifoClr), 32'd1);
    chk("dis_det", 32'(oObjectDetected), 32'd0);
    chk("dis_cnt_held", 32'(oHitCount), 32'd32);
    blank();
    chk("dis_clr_end", 32'(oFifoClr), 32'd0);
    frame(8, 4, 0, 0, -1, -1, -1);
    adv(IDLE, "dis_stay");
    chk("dis_no_clr", 32'(oFifoClr), 32'd0);

    // one-cycle reset in the middle of STORE
    iEnable = 1'b1;
    adv(FLUSH, "re_flush");
    blank();
    chk("re_wait", 32'(oState), 32'(WAIT));
    frame(8, 4, 0, 0, -1, -1, -1);
    adv(STORE, "re_store");
    frame(8, 4, 1, 0, -1, -1, 3);
    chk("rst_stays_idle", 32'(oState), 32'(IDLE));
    adv(FLUSH, "restart_flush");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/diff_frame_ctrl.md
Name: diff_frame_ctrl

Overview:
Sequencer for the frame-differencing datapath. It schedules the reference-frame FIFO in two phases: STORE writes subsampled pixels of one frame, and COMPARE reads them back against the next frame. It counts per-sample threshold hits, checks FIFO integrity, and publishes a frame-qualified detection flag. It sits between the CCD capture counters and the FIFO/comparator pair, and replaces the fixed frame-parity scheduling.

Parameters:
X_W, 10, width of iX_Cont
Y_W, 9, width of iY_Cont
SUB_PHASE, 2'b10, required {iX_Cont[0],iY_Cont[0]} for a sampled pixel
MIN_HITS, 30, hits per COMPARE frame needed to declare detection
CNT_W, 16, width of sample and hit counters

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-low reset
iEnable  in  1  run request; sampled only at frame boundaries
iDVAL  in  1  pixel valid
iFrame_Cont  in  32  capture frame counter
iX_Cont  in  X_W  pixel column
iY_Cont  in  Y_W  pixel row
iFifoEmpty  in  1  FIFO empty flag
iHit  in  1  comparator result; valid the cycle after oRdReq
oWrReq  out  1  FIFO write strobe
oRdReq  out  1  FIFO read strobe
oFifoClr  out  1  FIFO clear pulse (one cycle)
oObjectDetected  out  1  registered detection flag
oHitCount  out  CNT_W  hit count of the last completed COMPARE frame
oSyncErr  out  1  sticky error flag; cleared on re-entry to STORE
oState  out  3  current FSM state encoding (debug)

Behaviour:
- Reset (iRST=0 at posedge): state=IDLE; all outputs 0; counters 0; frame_q <= iFrame_Cont.
- Frame boundary: fb = (iFrame_Cont != frame_q), a one-cycle pulse. frame_q is updated every cycle.
- Sample: samp = iDVAL & ({iX_Cont[0],iY_Cont[0]} == SUB_PHASE).
- States:
  - IDLE: on fb with iEnable=1 -> FLUSH.
  - FLUSH: oFifoClr=1 for exactly one cycle, then -> WAIT.
  - WAIT: on the next fb -> STORE. Clear wr_cnt and oSyncErr.
  - STORE: oWrReq = samp (combinational); each write increments wr_cnt. On fb -> COMPARE; clear rd_cnt and hit_cnt.
  - COMPARE: oRdReq = samp & ~iFifoEmpty.
    - samp while iFifoEmpty=1 is an underflow: set oSyncErr; no read is issued.
    - A registered copy of oRdReq qualifies iHit; each qualified hit increments hit_cnt, saturating at all-ones.
    - On fb: perform the end-of-COMPARE check below.
- End-of-COMPARE check, evaluated on the fb cycle:
  - Mismatch: (rd_cnt != wr_cnt) | ~iFifoEmpty | oSyncErr. Set oSyncErr, hold oObjectDetected, -> FLUSH.
  - Otherwise, on the next cycle: oObjectDetected <= (hit_cnt_final >= MIN_HITS) and oHitCount <= hit_cnt_final. hit_cnt_final includes a hit arriving in the fb cycle itself. Then -> STORE, and clear wr_cnt.
- Latency: oWrReq/oRdReq are zero-cycle from pixel inputs. The decision is one cycle after fb.
- iEnable=0 seen at any fb in WAIT/STORE/COMPARE -> IDLE. On entry to IDLE: oFifoClr pulses one cycle, oObjectDetected clears, and oHitCount holds.
- Counters wrap never: wr_cnt saturates at all-ones. Saturation sets oSyncErr.
- fb and samp in the same cycle: the sample belongs to the new frame.
- Mid-operation reset returns to IDLE next cycle. No FIFO clear is issued; the FIFO's own aclr covers it.

Decomposition:
- Package diff_ctrl_pkg holds:
  - typedef enum logic[2:0] {IDLE, FLUSH, WAIT, STORE, COMPARE} state_t
  - the SUB_PHASE default constant
- Sub-module frame_edge_det generates frame_q and fb. Everything else stays in one always_ff FSM plus combinational strobe logic.

Test Plan:
- Reset with iEnable=1, then 3 frames of 8x4 pixels. Expect:
  - STORE issues 8 writes.
  - COMPARE issues 8 reads.
  - iHit=0 throughout -> oObjectDetected=0, oHitCount=0.
- COMPARE frame with iHit=1 on 30 of 30+ samples (use a larger frame). Expect oObjectDetected=1 one cycle after fb and oHitCount=30. With 29 hits: expect 0.
- FIFO underflow: iFifoEmpty forced 1 mid-COMPARE. Expect:
  - oRdReq suppressed, oSyncErr=1.
  - At fb: oFifoClr pulse, state FLUSH -> WAIT.
  - oObjectDetected unchanged.
- Count mismatch: STORE frame 8 samples, COMPARE frame 6 samples. Expect oSyncErr=1, FLUSH, then STORE after the following fb, with oSyncErr cleared.
- iEnable dropped during COMPARE. Expect:
  - Operation continues to fb, then IDLE.
  - oFifoClr one-cycle pulse, oObjectDetected=0.
  - No strobes afterwards.
- iRST=0 asserted for one cycle mid-STORE. Expect all outputs 0 next cycle and state IDLE. Restart requires fb with iEnable=1.
